seg7_scan: RTL

Four-digit multiplexed seven-segment scanner that consumes the free-running `clkdiv` counter bus. It watches one selected `clkdiv` bit and advances the active digit on each rising edge of that bit. Digit data is latched once per frame so a refresh cycle never shows mixed values. It drives active-low anodes and segments straight to the board display.

---
 rtl/seg7_scan.sv | 115 +++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner driven by one bit of a free-running divider.
// Digit data is captured once per frame so a refresh pass never mixes old and new values.
module seg7_scan #(
    parameter int SCAN_BIT = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic [15:0] hexs,
    input  logic [3:0]  points,
    input  logic [3:0]  blank,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_done
);

    logic        prev_q;
    logic        scan_bit;
    logic        tick;
    logic        wrap;
    logic [1:0]  idx_q,  idx_d;
    logic [15:0] sh_hex_q, sh_hex_d;
    logic [3:0]  sh_pt_q,  sh_pt_d;
    logic [3:0]  sh_bl_q,  sh_bl_d;
    logic        frame_done_q, frame_done_d;
    logic [3:0]  an_q,  an_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  digit_val;
    logic        unused_clkdiv;

    // Only one divider bit matters; the rest of the bus is folded away on purpose.
    assign unused_clkdiv = ^clkdiv;
    assign scan_bit      = clkdiv[SCAN_BIT];

    // prev resets high so a bit already set at reset release cannot tick.
    assign tick = scan_bit & ~prev_q;
    assign wrap = tick && (idx_q == 2'd3);

    function automatic logic [6:0] decode_hex(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        idx_d        = idx_q;
        sh_hex_d     = sh_hex_q;
        sh_pt_d      = sh_pt_q;
        sh_bl_d      = sh_bl_q;
        frame_done_d = 1'b0;
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
        if (wrap) begin
            sh_hex_d     = hexs;
            sh_pt_d      = points;
            sh_bl_d      = blank;
            frame_done_d = 1'b1;
        end
    end

    // Outputs come from the pre-edge idx and shadows, so they trail idx by one clock.
    always_comb begin
        digit_val = sh_hex_q[4*idx_q +: 4];
        an_d      = ~(4'b0001 << idx_q);
        seg_d     = 8'hFF;
        if (!sh_bl_q[idx_q]) begin
            seg_d = {~sh_pt_q[idx_q], decode_hex(digit_val)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q       <= 1'b1;
            idx_q        <= 2'd0;
            sh_hex_q     <= 16'h0000;
            sh_pt_q      <= 4'h0;
            sh_bl_q      <= 4'h0;
            frame_done_q <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 8'hFF;
        end else begin
            prev_q       <= scan_bit;
            idx_q        <= idx_d;
            sh_hex_q     <= sh_hex_d;
            sh_pt_q      <= sh_pt_d;
            sh_bl_q      <= sh_bl_d;
            frame_done_q <= frame_done_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule
